spi_read_buf: RTL and testbench

SPI_READ_BUF -- requirements
Module: spi_read_buf

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_rx_fifo.sv | 60 ++++++
 rtl/spi_read_buf.sv | 149 ++++++++++++++
 tb/tb_spi_read_buf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI read buffer: FSM states and FIFO entry layout.
package spi_pkg;

  localparam int unsigned SKIP_BYTES_DEF = 4;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned ENTRY_W        = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FLUSH   = 2'd3
  } spi_state_e;

  // One FIFO slot: end-of-frame marker plus payload byte.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head; drops pushes when full.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               valid,
  output logic               full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_n;
  logic               empty;
  logic               pop_acc;
  logic               push_acc;

  always_comb begin
    empty    = (count == '0);
    full_c   = (count == CNT_W'(DEPTH));
    pop_acc  = pop & ~empty;
    push_acc = push & (~full_c | pop_acc);
    rd_ptr_n = pop_acc ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n  = count + CNT_W'(push_acc) - CNT_W'(pop_acc);
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  // Head register tracks the entry at the next read pointer; bypass when that slot is written now.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      valid  <= (count_n != '0);
      head   <= (push_acc && (rd_ptr_n == wr_ptr)) ? push_data : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/spi_read_buf.sv
// SPI read-response buffer: strips per-frame header bytes and queues payload with end-of-frame marks.
module spi_read_buf
  import spi_pkg::*;
#(
  parameter int unsigned SKIP_BYTES = SKIP_BYTES_DEF,
  parameter int unsigned DEPTH      = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       spi_start,
  input  logic       spi_end,
  input  logic       rec_done,
  input  logic [7:0] data_rec,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [7:0] frame_bytes,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int unsigned SKIP_W = (SKIP_BYTES > 1) ? $clog2(SKIP_BYTES) : 1;

  spi_state_e        state, state_n;
  logic [SKIP_W-1:0] skip_cnt, skip_cnt_n;
  logic [7:0]        pay_cnt, pay_cnt_n;
  logic [7:0]        stage_data, stage_data_n;
  logic              stage_full, stage_full_n;
  logic              frame_done_n;
  logic [7:0]        frame_bytes_n;
  logic              overflow_n;
  logic              close_frame;
  logic              open_frame;
  logic              push;
  fifo_entry_t       push_entry;
  fifo_entry_t       head_entry;
  logic              fifo_full_c;
  logic              drop;

  spi_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .head      (head_entry),
    .valid     (out_valid),
    .full_c    (fifo_full_c)
  );

  assign out_data = head_entry.data;
  assign out_last = head_entry.last;

  always_comb begin
    state_n       = state;
    skip_cnt_n    = skip_cnt;
    pay_cnt_n     = pay_cnt;
    stage_data_n  = stage_data;
    stage_full_n  = stage_full;
    frame_done_n  = 1'b0;
    frame_bytes_n = frame_bytes;
    close_frame   = 1'b0;
    open_frame    = 1'b0;
    push          = 1'b0;
    push_entry    = '0;

    unique case (state)
      ST_IDLE: open_frame = spi_start;
      ST_SKIP: begin
        if (spi_start) begin
          close_frame = 1'b1;
          open_frame  = 1'b1;
        end else if (spi_end) begin
          close_frame = 1'b1;
        end else if (rec_done) begin
          if (32'(skip_cnt) + 32'd1 == SKIP_BYTES) state_n = ST_PAYLOAD;
          else skip_cnt_n = skip_cnt + SKIP_W'(1);
        end
      end
      ST_PAYLOAD: begin
        if (spi_start) begin
          close_frame = 1'b1;
          open_frame  = 1'b1;
        end else if (rec_done) begin
          // New byte displaces the staged one, which therefore cannot be the last.
          push            = stage_full;
          push_entry.data = stage_data;
          stage_data_n    = data_rec;
          stage_full_n    = 1'b1;
          pay_cnt_n       = (pay_cnt == 8'hFF) ? pay_cnt : pay_cnt + 8'd1;
          if (spi_end) state_n = ST_FLUSH;
        end else if (spi_end) begin
          close_frame = 1'b1;
        end
      end
      ST_FLUSH: begin
        close_frame = 1'b1;
        open_frame  = spi_start;
      end
      default: state_n = ST_IDLE;
    endcase

    if (close_frame) begin
      push            = stage_full;
      push_entry.last = 1'b1;
      push_entry.data = stage_data;
      stage_full_n    = 1'b0;
      frame_done_n    = 1'b1;
      frame_bytes_n   = pay_cnt;
      state_n         = ST_IDLE;
    end

    if (open_frame) begin
      skip_cnt_n   = '0;
      pay_cnt_n    = '0;
      stage_full_n = 1'b0;
      state_n      = (SKIP_BYTES == 0) ? ST_PAYLOAD : ST_SKIP;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    drop       = push & fifo_full_c & ~(out_valid & out_ready);
    overflow_n = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      skip_cnt    <= '0;
      pay_cnt     <= '0;
      stage_data  <= '0;
      stage_full  <= 1'b0;
      frame_done  <= 1'b0;
      frame_bytes <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      skip_cnt    <= skip_cnt_n;
      pay_cnt     <= pay_cnt_n;
      stage_data  <= stage_data_n;
      stage_full  <= stage_full_n;
      frame_done  <= frame_done_n;
      frame_bytes <= frame_bytes_n;
      overflow    <= overflow_n;
    end
  end

endmodule

// File: tb/tb_spi_read_buf.sv
// Testbench for spi_read_buf: directed frames plus random traffic against a queue-based frame model.
module tb_spi_read_buf;

  localparam int unsigned SKIP  = 4;
  localparam int unsigned DEPTH = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       spi_start = 1'b0;
  logic       spi_end   = 1'b0;
  logic       rec_done  = 1'b0;
  logic [7:0] data_rec  = 8'h00;
  logic       out_ready = 1'b0;
  logic       clr_ovf   = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       frame_done;
  logic [7:0] frame_bytes;
  logic       overflow;

  always #5 sys_clk = ~sys_clk;

  spi_read_buf #(.SKIP_BYTES(SKIP), .DEPTH(DEPTH)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .spi_start   (spi_start),
    .spi_end     (spi_end),
    .rec_done    (rec_done),
    .data_rec    (data_rec),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_done  (frame_done),
    .frame_bytes (frame_bytes),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_fd  = 0;
  int n_pop = 0;

  // Frame-level reference: header count, pending byte, byte total, output queue.
  bit         m_active;
  bit         m_flush;
  bit         m_have_pend;
  logic [7:0] m_pend;
  int         m_hdr;
  int         m_nbytes;
  logic [8:0] m_q[$];
  bit         m_fd;
  int         m_fb;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit         pop, push, drop, do_close, do_open;
    logic [8:0] pv;
    pop      = (m_q.size() != 0) && out_ready;
    push     = 1'b0;
    pv       = '0;
    do_close = 1'b0;
    do_open  = 1'b0;
    m_fd     = 1'b0;
    if (sys_rst) begin
      m_q.delete();
      m_active = 0; m_flush = 0; m_have_pend = 0; m_pend = '0;
      m_hdr = 0; m_nbytes = 0; m_fb = 0; m_ovf = 0;
      return;
    end
    if (m_flush) begin
      do_close = 1'b1;
      do_open  = spi_start;
    end else if (!m_active) begin
      do_open = spi_start;
    end else if (spi_start) begin
      do_close = 1'b1;
      do_open  = 1'b1;
    end else if (m_hdr < int'(SKIP)) begin
      if (spi_end) do_close = 1'b1;
      else if (rec_done) m_hdr++;
    end else if (rec_done) begin
      if (m_have_pend) begin push = 1'b1; pv = {1'b0, m_pend}; end
      m_pend = data_rec;
      m_have_pend = 1'b1;
      m_nbytes++;
      if (spi_end) m_flush = 1'b1;
    end else if (spi_end) begin
      do_close = 1'b1;
    end
    if (do_close) begin
      if (m_have_pend) begin push = 1'b1; pv = {1'b1, m_pend}; end
      m_have_pend = 0;
      m_fd = 1'b1;
      m_fb = (m_nbytes > 255) ? 255 : m_nbytes;
      m_active = 0;
      m_flush = 0;
    end
    if (do_open) begin
      m_active = 1; m_hdr = 0; m_nbytes = 0; m_have_pend = 0;
    end
    drop = push && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(pv);
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic check_all();
    logic [8:0] h;
    chk("out_valid", 9'(out_valid), 9'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      h = m_q[0];
      chk("out_data", 9'(out_data), 9'(h[7:0]));
      chk("out_last", 9'(out_last), 9'(h[8]));
    end
    chk("frame_done", 9'(frame_done), 9'(m_fd));
    chk("frame_bytes", 9'(frame_bytes), 9'(m_fb));
    chk("overflow", 9'(overflow), 9'(m_ovf));
  endtask

  task automatic tick();
    if (out_valid && out_ready && !sys_rst) n_pop++;
    model_step();
    @(posedge sys_clk);
    #1;
    if (frame_done) n_fd++;
    check_all();
    spi_start = 1'b0;
    spi_end   = 1'b0;
    rec_done  = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] d);
    rec_done = 1'b1;
    data_rec = d;
    tick();
    tick();
  endtask

  task automatic start_hdr();
    spi_start = 1'b1;
    tick();
    for (int i = 0; i < int'(SKIP); i++) send(8'($urandom));
  endtask

  task automatic end_frame();
    spi_end = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int fd0, pop0;

    // Reset
    idle(2);
    chk("rst_out_data", 9'(out_data), 9'h000);
    chk("rst_out_last", 9'(out_last), 9'h000);
    sys_rst = 1'b0;
    idle(2);

    // Eleven-byte frame, consumer always ready
    out_ready = 1'b1;
    fd0 = n_fd;
    start_hdr();
    for (int i = 0; i < 11; i++) send(8'(8'hA1 + i));
    end_frame();
    idle(3);
    chk("f1_frame_bytes", 9'(frame_bytes), 9'd11);
    chk("f1_frame_done_cnt", 9'(n_fd - fd0), 9'd1);

    // End coincident with last byte takes the flush path
    start_hdr();
    for (int i = 0; i < 10; i++) send(8'(8'hA1 + i));
    rec_done = 1'b1; data_rec = 8'hAB; spi_end = 1'b1;
    tick();
    chk("flush_last", 9'({out_last, out_data}), 9'h0AA);
    tick();
    chk("flush_done", 9'(frame_done), 9'd1);
    idle(3);
    chk("flush_frame_bytes", 9'(frame_bytes), 9'd11);

    // Twenty bytes into a stalled sixteen-entry FIFO
    out_ready = 1'b0;
    start_hdr();
    for (int i = 1; i <= 20; i++) send(8'(i));
    end_frame();
    chk("ovf_set", 9'(overflow), 9'd1);
    chk("ovf_frame_bytes", 9'(frame_bytes), 9'd20);
    chk("ovf_head", 9'({out_last, out_data}), 9'h001);
    clr_ovf = 1'b1;
    tick();
    chk("ovf_clr", 9'(overflow), 9'd0);
    out_ready = 1'b1;
    pop0 = n_pop;
    idle(20);
    chk("ovf_held_entries", 9'(n_pop - pop0), 9'd16);

    // Header-only frame
    start_hdr();
    end_frame();
    chk("empty_frame_bytes", 9'(frame_bytes), 9'd0);
    chk("empty_no_valid", 9'(out_valid), 9'd0);

    // Restart mid-payload closes the running frame
    out_ready = 1'b0;
    start_hdr();
    send(8'h55);
    send(8'h66);
    start_hdr();
    chk("restart_fb", 9'(frame_bytes), 9'd2);
    send(8'h77);
    send(8'h88);
    end_frame();
    chk("restart_fb2", 9'(frame_bytes), 9'd2);
    out_ready = 1'b1;
    idle(6);

    // Reset with three bytes queued and one staged
    out_ready = 1'b0;
    start_hdr();
    for (int i = 1; i <= 4; i++) send(8'(8'hC0 + i));
    chk("pre_rst_valid", 9'(out_valid), 9'd1);
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_valid", 9'(out_valid), 9'd0);
    chk("mid_rst_fd", 9'(frame_done), 9'd0);
    sys_rst = 1'b0;
    idle(3);

    // Random traffic: busy consumer, then slow consumer
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      spi_start = ($urandom_range(0, 59) == 0);
      spi_end   = ($urandom_range(0, 24) == 0);
      rec_done  = ($urandom_range(0, 1) == 0);
      data_rec  = 8'($urandom);
      clr_ovf   = ($urandom_range(0, 49) == 0);
      tick();
    end
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 9) == 0);
      spi_start = ($urandom_range(0, 99) == 0);
      spi_end   = ($urandom_range(0, 39) == 0);
      rec_done  = ($urandom_range(0, 1) == 0);
      data_rec  = 8'($urandom);
      clr_ovf   = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
